// File: rtl/video_stream_framer.sv
// Frames the raw FIFO read stream into valid/sof/eol pixels.
// Tracks line and frame geometry and keeps sticky line/frame error flags.
module video_stream_framer #(
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              vs_in,
  input  logic              err_clr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_sof,
  output logic              m_eol,
  output logic              line_err,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam int H_W = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam int V_W = $clog2(V_DISP + 1);
  localparam logic [H_W-1:0] H_LAST = H_W'(H_DISP - 1);
  localparam logic [V_W-1:0] V_FULL = V_W'(V_DISP);

  typedef enum logic [0:0] {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // state is the FSM register; bind checkers against it directly
  state_t           state, state_n;
  logic [H_W-1:0]   h_cnt, h_n;
  logic [V_W-1:0]   v_cnt, v_n;
  logic             ovf, ovf_n;
  logic             sof_pend, sof_n;
  logic [RD_LAT-1:0] rd_sr;
  logic             vld;

  logic [DATA_W-1:0] data_n;
  logic              valid_n, sofo_n, eolo_n;
  logic              lerr_n, ferr_n;
  logic [15:0]       fcnt_n;

  logic              open;
  logic [H_W-1:0]    cur_h;
  logic [V_W-1:0]    cur_v;
  logic              cur_sof;
  logic              lerr_ev, ferr_ev;

  assign vld = rd_sr[RD_LAT-1];

  // A vs_in pulse closes the running frame before the same-cycle pixel is
  // considered, so that pixel becomes the first pixel of the next frame.
  always_comb begin
    state_n = state;
    h_n     = h_cnt;
    v_n     = v_cnt;
    ovf_n   = ovf;
    sof_n   = sof_pend;
    data_n  = m_data;
    valid_n = 1'b0;
    sofo_n  = 1'b0;
    eolo_n  = 1'b0;
    fcnt_n  = frame_cnt;
    lerr_ev = 1'b0;
    ferr_ev = 1'b0;
    open    = (state == ACTIVE) || vs_in;
    cur_h   = vs_in ? '0 : h_cnt;
    cur_v   = vs_in ? '0 : v_cnt;
    cur_sof = vs_in ? 1'b1 : sof_pend;

    if (vs_in) begin
      if (state == ACTIVE) begin
        if (v_cnt == V_FULL && h_cnt == '0 && !ovf) begin
          fcnt_n = frame_cnt + 16'd1;
        end else begin
          ferr_ev = 1'b1;
          if (h_cnt != '0) lerr_ev = 1'b1;
        end
      end
      state_n = ACTIVE;
      h_n     = '0;
      v_n     = '0;
      ovf_n   = 1'b0;
      sof_n   = 1'b1;
    end

    if (open) begin
      if (vld) begin
        valid_n = 1'b1;
        data_n  = fifo_dout;
        sofo_n  = cur_sof;
        sof_n   = 1'b0;
        if (cur_h == H_LAST) begin
          eolo_n = 1'b1;
          h_n    = '0;
          // v_cnt saturates; the extra line is remembered for the vs_in check
          if (cur_v == V_FULL) ovf_n = 1'b1;
          else                 v_n   = cur_v + 1'b1;
        end else begin
          h_n = cur_h + 1'b1;
        end
      end else if (cur_h != '0) begin
        lerr_ev = 1'b1;
        h_n     = '0;
      end
    end

    lerr_n = err_clr ? 1'b0 : line_err;
    ferr_n = err_clr ? 1'b0 : frame_err;
    if (lerr_ev) lerr_n = 1'b1;
    if (ferr_ev) ferr_n = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sr <= '0;
    end else begin
      rd_sr[0] <= fifo_rd_en;
      for (int i = 1; i < RD_LAT; i++) rd_sr[i] <= rd_sr[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SYNC;
      h_cnt     <= '0;
      v_cnt     <= '0;
      ovf       <= 1'b0;
      sof_pend  <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_sof     <= 1'b0;
      m_eol     <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      h_cnt     <= h_n;
      v_cnt     <= v_n;
      ovf       <= ovf_n;
      sof_pend  <= sof_n;
      m_data    <= data_n;
      m_valid   <= valid_n;
      m_sof     <= sofo_n;
      m_eol     <= eolo_n;
      line_err  <= lerr_n;
      frame_err <= ferr_n;
      frame_cnt <= fcnt_n;
    end
  end

endmodule

// File: tb/tb_video_stream_framer.sv
// Bench for video_stream_framer: two instances (read latency 1 and 3) fed the
// same logical event stream, checked cycle by cycle against a frame-level model.
module tb_video_stream_framer;

  localparam int H_DISP = 8;
  localparam int V_DISP = 4;
  localparam int DATA_W = 16;

  typedef struct {
    bit              vld;
    bit              vs;
    bit              clr;
    bit              rst;
    logic [DATA_W-1:0] pix;
  } ev_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              rd_en_a, rd_en_b;
  logic [DATA_W-1:0] dout;
  logic              vs_in, err_clr;

  logic [DATA_W-1:0] a_data, b_data;
  logic a_valid, a_sof, a_eol, a_lerr, a_ferr;
  logic b_valid, b_sof, b_eol, b_lerr, b_ferr;
  logic [15:0] a_fcnt, b_fcnt;

  video_stream_framer #(.H_DISP(H_DISP), .V_DISP(V_DISP), .DATA_W(DATA_W), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .fifo_rd_en(rd_en_a), .fifo_dout(dout), .vs_in(vs_in),
    .err_clr(err_clr), .m_data(a_data), .m_valid(a_valid), .m_sof(a_sof), .m_eol(a_eol),
    .line_err(a_lerr), .frame_err(a_ferr), .frame_cnt(a_fcnt)
  );

  video_stream_framer #(.H_DISP(H_DISP), .V_DISP(V_DISP), .DATA_W(DATA_W), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .fifo_rd_en(rd_en_b), .fifo_dout(dout), .vs_in(vs_in),
    .err_clr(err_clr), .m_data(b_data), .m_valid(b_valid), .m_sof(b_sof), .m_eol(b_eol),
    .line_err(b_lerr), .frame_err(b_ferr), .frame_cnt(b_fcnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_act;
  int col, rows;
  bit sofp;
  bit e_valid, e_sof, e_eol, e_lerr, e_ferr;
  logic [DATA_W-1:0] e_data;
  logic [15:0] e_fcnt;
  logic [DATA_W-1:0] exp_q[$];
  int got_pix_a, got_pix_b;

  task automatic model_reset();
    m_act = 0; col = 0; rows = 0; sofp = 0;
    e_valid = 0; e_sof = 0; e_eol = 0; e_lerr = 0; e_ferr = 0;
    e_data = '0; e_fcnt = '0;
  endtask

  task automatic model_step(input ev_t e);
    bit lev, fev;
    lev = 0; fev = 0;
    e_valid = 0; e_sof = 0; e_eol = 0;
    if (e.vs) begin
      if (m_act) begin
        if (rows == V_DISP && col == 0) e_fcnt = e_fcnt + 16'd1;
        else begin
          fev = 1;
          if (col != 0) lev = 1;
        end
      end
      m_act = 1; col = 0; rows = 0; sofp = 1;
    end
    if (m_act) begin
      if (e.vld) begin
        e_valid = 1; e_data = e.pix; e_sof = sofp; sofp = 0;
        exp_q.push_back(e.pix);
        col++;
        if (col == H_DISP) begin
          e_eol = 1; col = 0; rows++;
        end
      end else if (col != 0) begin
        lev = 1; col = 0;
      end
    end
    if (e.clr) begin
      e_lerr = 0; e_ferr = 0;
    end
    if (lev) e_lerr = 1;
    if (fev) e_ferr = 1;
  endtask

  task automatic compare_dut(input string p, input logic [DATA_W-1:0] d, input logic v,
                             input logic s, input logic eo, input logic le, input logic fe,
                             input logic [15:0] fc);
    check({p, "_valid"}, 32'(v), 32'(e_valid));
    check({p, "_data"}, 32'(d), 32'(e_data));
    check({p, "_sof"}, 32'(s), 32'(e_sof));
    check({p, "_eol"}, 32'(eo), 32'(e_eol));
    check({p, "_line_err"}, 32'(le), 32'(e_lerr));
    check({p, "_frame_err"}, 32'(fe), 32'(e_ferr));
    check({p, "_frame_cnt"}, 32'(fc), 32'(e_fcnt));
  endtask

  // ---------------- stimulus builder ----------------
  ev_t ev_q[$];

  task automatic push(input bit vld, input bit vs, input bit clr, input bit r);
    ev_t e;
    e.vld = vld; e.vs = vs; e.clr = clr; e.rst = r;
    e.pix = DATA_W'($urandom);
    ev_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(0, 0, 0, 0);
  endtask

  task automatic push_line(input int n, input bit vs_first);
    for (int i = 0; i < n; i++) push(1, vs_first && i == 0, 0, 0);
  endtask

  task automatic push_lines(input int n);
    for (int i = 0; i < n; i++) begin
      push_line(H_DISP, 0);
      push_idle(2);
    end
  endtask

  function automatic bit la(input int idx);
    return (idx < ev_q.size()) ? ev_q[idx].vld : 1'b0;
  endfunction

  initial begin
    ev_t e;
    int nl, len;
    rd_en_a = 0; rd_en_b = 0; dout = '0; vs_in = 0; err_clr = 0;

    for (int i = 0; i < 3; i++) push(0, 0, 0, 1);
    push_idle(4);
    push_line(H_DISP, 0);                 // before any vs_in: discarded
    push_idle(2);
    push_line(H_DISP, 1);                 // vs_in coincident with first pixel
    push_idle(2);
    push_lines(V_DISP - 1);
    push(0, 1, 0, 0);                     // good frame close
    push_line(5, 0); push_idle(2);        // short line
    push_lines(V_DISP);
    push(0, 1, 0, 0);                     // good despite short line
    push(0, 0, 1, 0);                     // clear
    push_lines(V_DISP - 1);
    push(0, 1, 0, 0);                     // under-count
    push_lines(V_DISP);
    push(0, 1, 0, 0);                     // good, frame_err stays
    push_lines(V_DISP + 1);
    push(0, 1, 0, 0);                     // over-count
    push_lines(2); push_line(3, 0);
    push(0, 1, 0, 0);                     // vs mid-line
    push(0, 0, 1, 0);
    push_line(3, 0);
    push_line(H_DISP, 1);                 // vs with a pixel, mid-line
    push_idle(1);
    push_line(3, 0);
    push(0, 0, 1, 0);                     // clear coincident with gap error
    push(0, 0, 1, 0);

    for (int f = 0; f < 30; f++) begin
      push(($urandom_range(0, 2) == 0), 1, 0, 0);
      if (ev_q[ev_q.size()-1].vld) begin
        push_line(H_DISP - 1, 0); push_idle($urandom_range(0, 2));
      end
      nl = ($urandom_range(0, 5) == 0) ? $urandom_range(V_DISP - 1, V_DISP + 1) : V_DISP;
      for (int l = 0; l < nl; l++) begin
        len = ($urandom_range(0, 11) == 0) ? $urandom_range(1, H_DISP - 1) : H_DISP;
        push_line(len, 0);
        push(0, 0, ($urandom_range(0, 15) == 0), 0);
        push_idle($urandom_range(0, 2));
      end
    end

    push(0, 1, 0, 0);
    push_lines(2); push_line(4, 0);
    for (int i = 0; i < 3; i++) push(0, 0, 0, 1);   // reset mid-line
    push_idle(4);
    push_line(6, 0);                                 // discarded in SYNC
    push_idle(2);
    push(0, 1, 0, 0);
    push_lines(V_DISP);
    push(0, 1, 0, 0);
    push_idle(6);

    // pixels whose read strobe would straddle a reset are not generated
    for (int i = 0; i < ev_q.size(); i++)
      if (ev_q[i].rst)
        for (int k = i; k < i + 4 && k < ev_q.size(); k++) ev_q[k].vld = 0;

    model_reset();
    got_pix_a = 0; got_pix_b = 0;
    for (int c = 0; c < ev_q.size(); c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      if (c > 0) begin
        compare_dut("a", a_data, a_valid, a_sof, a_eol, a_lerr, a_ferr, a_fcnt);
        compare_dut("b", b_data, b_valid, b_sof, b_eol, b_lerr, b_ferr, b_fcnt);
        if (a_valid) got_pix_a++;
        if (b_valid) got_pix_b++;
      end
      e = ev_q[c];
      rst     = e.rst;
      rd_en_a = la(c + 1);
      rd_en_b = la(c + 3);
      dout    = e.pix;
      vs_in   = e.vs;
      err_clr = e.clr;
      if (e.rst) begin
        model_reset();
        #1;
        compare_dut("a_rst", a_data, a_valid, a_sof, a_eol, a_lerr, a_ferr, a_fcnt);
        compare_dut("b_rst", b_data, b_valid, b_sof, b_eol, b_lerr, b_ferr, b_fcnt);
      end else begin
        model_step(e);
      end
    end

    check("a_pixel_total", 32'(got_pix_a), 32'(exp_q.size()));
    check("b_pixel_total", 32'(got_pix_b), 32'(exp_q.size()));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
